pipe_carry_adder: RTL and testbench



---
 rtl/pipe_carry_adder.sv | 106 ++++++++++
 tb/tb_pipe_carry_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_carry_adder.sv
// Pipelined ripple-carry add/sub: STAGES register slices, latency STAGES, one beat per clock.
// Global stall when out_valid && !out_ready; optional clamp via PIPE_CARRY_ADDER_SAT_EN.
module pipe_carry_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
`ifdef PIPE_CARRY_ADDER_SAT_EN
   input  logic             sat,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SW = WIDTH / STAGES;
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   // a/b carry the not-yet-added upper slices, s accumulates finished lower slices
   typedef struct packed {
      logic             vld;
      logic             c;
      logic             sat;
      logic             ovf;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] s;
   } stage_t;

   stage_t        stage_q [STAGES];
   stage_t        stage_d [STAGES];
   stage_t        src;
   stage_t        nxt;
   logic [SW:0]   slc;
   logic          stall;
   logic          sat_in;

`ifdef PIPE_CARRY_ADDER_SAT_EN
   assign sat_in = sat;
`else
   assign sat_in = 1'b0;
`endif

   assign stall    = stage_q[STAGES-1].vld && !out_ready;
   assign in_ready = !stall;

   always_comb begin
      stage_d = stage_q;
      src     = '0;
      nxt     = '0;
      slc     = '0;
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            src.vld = in_valid && in_ready;
            src.c   = sub ? 1'b1 : cin;
            src.sat = sat_in;
            src.ovf = 1'b0;
            src.a   = a;
            src.b   = sub ? ~b : b;
            src.s   = '0;
         end else begin
            src = stage_q[k-1];
         end
         slc = {1'b0, src.a[k*SW +: SW]} + {1'b0, src.b[k*SW +: SW]} + {{SW{1'b0}}, src.c};
         nxt = src;
         nxt.s[k*SW +: SW] = slc[SW-1:0];
         nxt.c = slc[SW];
         if (k == STAGES-1) begin
            nxt.ovf = (src.a[WIDTH-1] == src.b[WIDTH-1]) && (nxt.s[WIDTH-1] != src.a[WIDTH-1]);
            if (nxt.sat && nxt.ovf)
               nxt.s = src.a[WIDTH-1] ? SAT_NEG : SAT_POS;
         end
         // bubbles advance as invalid but leave data untouched so outputs hold
         if (!stall) begin
            stage_d[k].vld = src.vld;
            if (src.vld)
               stage_d[k] = nxt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++)
            stage_q[k] <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign out_valid = stage_q[STAGES-1].vld;
   assign sum       = stage_q[STAGES-1].s;
   assign cout      = stage_q[STAGES-1].c;
   assign ovf       = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipe_carry_adder.sv
// Directed + random bench for pipe_carry_adder with an in-order result scoreboard.
module tb_pipe_carry_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_i;
   logic [15:0] b_i;
   logic        cin_i;
   logic        sub_i;
   logic        sat_i;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   int vectors     = 0;
   int miscompares = 0;
   int popped      = 0;
   logic [17:0] sb[$];

   always #5 clk = ~clk;

   pipe_carry_adder #(.WIDTH(16), .STAGES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .cin       (cin_i),
      .sub       (sub_i),
`ifdef PIPE_CARRY_ADDER_SAT_EN
      .sat       (sat_i),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub, input logic sat);
      logic [15:0] be;
      logic [16:0] r;
      logic [15:0] s;
      logic        ov;
      be = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, be} + {16'b0, (sub ? 1'b1 : cin)};
      ov = (a[15] == be[15]) && (r[15] != a[15]);
      s  = r[15:0];
`ifdef PIPE_CARRY_ADDER_SAT_EN
      if (sat && ov) s = a[15] ? 16'h8000 : 16'h7FFF;
`else
      if (sat && 1'b0) s = 16'h0;
`endif
      return {s, r[16], ov};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // scoreboard consumer: every handshaken result must match the oldest pending beat
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         logic [17:0] e;
         e = (sb.size() > 0) ? sb.pop_front() : 18'bx;
         chk("result", {14'b0, sum, cout, ovf}, {14'b0, e});
         popped++;
      end
   end

   // presents one beat starting just after a rising edge; returns cycles spent waiting
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input logic sat, output int waits);
      logic ok;
      in_valid = 1'b1; a_i = a; b_i = b; cin_i = cin; sub_i = sub; sat_i = sat;
      waits = 0;
      ok = 1'b0;
      while (!ok && waits < 50) begin
         @(negedge clk);
         ok = in_ready;
         if (ok) sb.push_back(model(a, b, cin, sub, sat));
         @(posedge clk); #1;
         if (!ok) waits++;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain;
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      chk("drain", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int          w;
      int          lat;
      int          idx;
      int          hold;
      int          p0;
      logic        seen;
      logic [15:0] first;
      logic [15:0] ba[6];
      logic [15:0] bb[6];
      logic        bc[6];
      logic        bs[6];

      rst_n = 1'b0; in_valid = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
      sat_i = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);

      // full carry ripple through every slice
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, w);
      lat = 1;
      @(negedge clk);
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("carry_latency", lat, 4);
      chk("carry_sum", sum, 16'h0000);
      chk("carry_cout", cout, 1);
      chk("carry_ovf", ovf, 0);
      @(negedge clk);
      chk("carry_pulse", out_valid, 0);
      @(posedge clk); #1;

      // subtract / signed overflow / wrap
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, w);
      send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, w);
      send(16'h7FFF, 16'h0001, 1'b1, 1'b1, 1'b0, w);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, w);
      drain();

      // streaming at full rate
      for (int i = 0; i < 100; i++) begin
         send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, w);
         chk("stream_no_stall", w, 0);
      end
      drain();

      // backpressure: hold out_ready low for 5 cycles once the first result shows
      for (int i = 0; i < 6; i++) begin
         ba[i] = 16'($urandom); bb[i] = 16'($urandom); bc[i] = 1'($urandom); bs[i] = 1'($urandom);
      end
      idx = 0; hold = 0; seen = 1'b0; first = '0; p0 = popped;
      for (int cyc = 0; cyc < 80; cyc++) begin
         if (!seen && out_valid === 1'b1) begin
            seen = 1'b1; hold = 5; out_ready = 1'b0; first = sum;
         end
         in_valid = (idx < 6);
         if (idx < 6) begin
            a_i = ba[idx]; b_i = bb[idx]; cin_i = bc[idx]; sub_i = bs[idx]; sat_i = 1'b0;
         end
         @(negedge clk);
         if (hold > 0) begin
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid_held", out_valid, 1);
            chk("bp_sum_stable", sum, first);
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(ba[idx], bb[idx], bc[idx], bs[idx], 1'b0));
            idx++;
         end
         @(posedge clk); #1;
         if (hold > 0) begin
            hold--;
            if (hold == 0) out_ready = 1'b1;
         end
         if (seen && hold == 0 && idx == 6 && sb.size() == 0) break;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("bp_seen_first", seen, 1);
      chk("bp_all_sent", idx, 6);
      drain();
      chk("bp_result_count", popped - p0, 6);

      // reset with three beats in flight
      send(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, w);
      send(16'h2222, 16'h0101, 1'b1, 1'b0, 1'b0, w);
      send(16'h4000, 16'h0002, 1'b0, 1'b1, 1'b0, w);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("rst_mid_valid_seen", out_valid, 1);
      #2 rst_n = 1'b0;
      #1 chk("rst_async_drop", out_valid, 0);
      sb.delete();
      @(posedge clk); #3 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("rst_quiet", out_valid, 0);
      end
      chk("rst_in_ready_after", in_ready, 1);
      @(posedge clk); #1;

`ifdef PIPE_CARRY_ADDER_SAT_EN
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, w);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, w);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, w);
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
